// File: rtl/random_spawn_timer_if.sv
// ----------------------------------------------------------------------------
// random_spawn_timer_if
//   Spawn-request handshake between the spawn timer (master) and the game
//   logic that consumes spawns (slave). A request is offered with oSpawnValid
//   and the lane it targets; it is taken on a cycle where iSpawnReady is also
//   high.
//
//   Signals
//     oSpawnValid  master -> slave  spawn request pending
//     oSpawnLane   master -> slave  lane of the pending spawn (LANE_W bits)
//     iSpawnReady  slave -> master  consumer accepts the pending spawn
//
//   LANE_W must equal $clog2(LANES) of the timer this interface connects to.
// ----------------------------------------------------------------------------
interface random_spawn_timer_if #(
    parameter int LANE_W = 2
);
    logic              oSpawnValid;
    logic [LANE_W-1:0] oSpawnLane;
    logic              iSpawnReady;

    modport master (
        output oSpawnValid,
        output oSpawnLane,
        input  iSpawnReady
    );

    modport slave (
        input  oSpawnValid,
        input  oSpawnLane,
        output iSpawnReady
    );
endinterface

// File: rtl/random_spawn_timer.sv
// ----------------------------------------------------------------------------
// random_spawn_timer
//   Turns a pseudo-random stream into timed game events. A random interval is
//   sampled (clamped to [MIN_INTERVAL, MAX_INTERVAL]), counted down, and then
//   a spawn request carrying a random lane is raised and held until the game
//   logic accepts it. The countdown can be paused, and the scheduler can be
//   disabled, except while a request is pending.
//
//   Ports
//     iClock       in   system clock, rising edge
//     iResetN      in   asynchronous active-low reset
//     iEnable      in   1 = run the scheduler, 0 = fall back to IDLE
//     iPause       in   1 = freeze the countdown
//     iRandom      in   random value, a fresh one every cycle (WIDTH bits)
//     spawn        if   master side of the spawn handshake
//     oSpawnCount  out  accepted spawns since reset, wraps at 16 bits
//     oRemaining   out  current countdown value, 0 outside COUNT
// ----------------------------------------------------------------------------
module random_spawn_timer #(
    parameter int  WIDTH        = 32,
    parameter int  MIN_INTERVAL = 16,
    parameter int  MAX_INTERVAL = 4096,
    parameter int  LANES        = 4,
    localparam int LANE_W       = $clog2(LANES)
) (
    input  logic                 iClock,
    input  logic                 iResetN,
    input  logic                 iEnable,
    input  logic                 iPause,
    input  logic [WIDTH-1:0]     iRandom,
    random_spawn_timer_if.master spawn,
    output logic [15:0]          oSpawnCount,
    output logic [WIDTH-1:0]     oRemaining
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        FIRE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_I = WIDTH'(MIN_INTERVAL);
    localparam logic [WIDTH-1:0] MAX_I = WIDTH'(MAX_INTERVAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_t            state;
    logic [WIDTH-1:0]  counter;
    logic [LANE_W-1:0] spawn_lane;
    logic              spawn_valid;
    logic [15:0]       spawn_count;
    logic [WIDTH-1:0]  interval;

    // Unsigned clamp of the current random sample into the legal interval range.
    assign interval = (iRandom < MIN_I) ? MIN_I :
                      (iRandom > MAX_I) ? MAX_I : iRandom;

    // NOTE: every piece of state lives in this one clocked block and is updated
    // with non-blocking assignments, so each branch reads the pre-edge values
    // no matter the statement order.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state       <= IDLE;
            counter     <= '0;
            spawn_lane  <= '0;
            spawn_valid <= 1'b0;
            spawn_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    counter <= '0;
                    if (iEnable) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    counter <= interval;
                    state   <= COUNT;
                end

                COUNT: begin
                    // Disable wins over pause so a paused scheduler can still be stopped.
                    if (!iEnable) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else if (iPause) begin
                        counter <= counter;
                    end else if (counter == ONE) begin
                        // Counter is cleared here so oRemaining reads 0 while firing.
                        counter     <= '0;
                        spawn_lane  <= iRandom[LANE_W-1:0];
                        spawn_valid <= 1'b1;
                        state       <= FIRE;
                    end else begin
                        counter <= counter - ONE;
                    end
                end

                FIRE: begin
                    // The request is never withdrawn: only acceptance leaves FIRE.
                    if (spawn.iSpawnReady) begin
                        spawn_valid <= 1'b0;
                        spawn_count <= spawn_count + 16'd1;
                        state       <= iEnable ? LOAD : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign spawn.oSpawnValid = spawn_valid;
    assign spawn.oSpawnLane  = spawn_lane;
    assign oSpawnCount       = spawn_count;
    assign oRemaining        = counter;

endmodule

// File: tb/tb_random_spawn_timer.sv
// ----------------------------------------------------------------------------
// tb_random_spawn_timer
//   Self-checking bench for random_spawn_timer. Each scenario task pushes the
//   spawns it expects (cycle of first valid, lane, spawn count at that time)
//   into a scoreboard queue while driving stimulus, then pops and compares as
//   the DUT raises oSpawnValid. Inputs change and outputs are sampled on the
//   falling clock edge; cyc counts rising edges.
// ----------------------------------------------------------------------------
module tb_random_spawn_timer;

    localparam int WIDTH  = 32;
    localparam int MIN_I  = 16;
    localparam int MAX_I  = 4096;
    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef struct {
        int                cyc;
        logic [LANE_W-1:0] lane;
        logic [15:0]       count;
    } spawn_exp_t;

    logic             iClock  = 1'b0;
    logic             iResetN = 1'b0;
    logic             iEnable = 1'b0;
    logic             iPause  = 1'b0;
    logic [WIDTH-1:0] iRandom = '0;
    logic [15:0]      oSpawnCount;
    logic [WIDTH-1:0] oRemaining;

    random_spawn_timer_if #(.LANE_W(LANE_W)) spawn_if ();

    random_spawn_timer #(
        .WIDTH        (WIDTH),
        .MIN_INTERVAL (MIN_I),
        .MAX_INTERVAL (MAX_I),
        .LANES        (LANES)
    ) dut (
        .iClock      (iClock),
        .iResetN     (iResetN),
        .iEnable     (iEnable),
        .iPause      (iPause),
        .iRandom     (iRandom),
        .spawn       (spawn_if),
        .oSpawnCount (oSpawnCount),
        .oRemaining  (oRemaining)
    );

    always #5 iClock = ~iClock;

    int          cyc         = 0;
    int          checks      = 0;
    int          errors      = 0;
    logic [15:0] model_count = '0;
    spawn_exp_t  sb[$];

    always @(posedge iClock) cyc <= cyc + 1;

    // Waits (bounded) for the next falling edge on which oSpawnValid is high.
    task automatic wait_valid(input int budget, output int seen, output bit ok);
        ok   = 1'b0;
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge iClock);
            if (spawn_if.oSpawnValid === 1'b1) begin
                ok   = 1'b1;
                seen = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iResetN = 1'b0;
        iEnable = 1'b0;
        iPause  = 1'b0;
        iRandom = '0;
        spawn_if.iSpawnReady = 1'b0;
        repeat (3) @(negedge iClock);
        checks++;
        if (spawn_if.oSpawnValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", spawn_if.oSpawnValid);
        end
        checks++;
        if (spawn_if.oSpawnLane !== 2'd0) begin
            errors++;
            $display("FAIL reset_lane: got %0d expected 0", spawn_if.oSpawnLane);
        end
        checks++;
        if (oSpawnCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", oSpawnCount);
        end
        checks++;
        if (oRemaining !== '0) begin
            errors++;
            $display("FAIL reset_remaining: got %0d expected 0", oRemaining);
        end
        iResetN = 1'b1;
        repeat (2) @(negedge iClock);
        checks++;
        if (oRemaining !== '0 || spawn_if.oSpawnValid !== 1'b0) begin
            errors++;
            $display("FAIL idle_disabled: got remaining %0d valid %b expected 0 0",
                     oRemaining, spawn_if.oSpawnValid);
        end
    endtask

    task automatic test_back_to_back();
        int c, seen;
        bit ok;
        spawn_exp_t e;
        iRandom = 32'd100;
        spawn_if.iSpawnReady = 1'b1;
        iEnable = 1'b1;
        c = cyc;
        for (int k = 0; k < 3; k++)
            sb.push_back(spawn_exp_t'{c + 102 * (k + 1), 2'd0, model_count + 16'(k)});
        for (int k = 0; k < 3; k++) begin
            wait_valid(150, seen, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || seen != e.cyc) begin
                errors++;
                $display("FAIL b2b_time[%0d]: got cycle %0d expected %0d", k, seen, e.cyc);
            end
            if (ok) begin
                checks++;
                if (spawn_if.oSpawnLane !== e.lane || oSpawnCount !== e.count) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got lane %0d count %0d expected %0d %0d",
                             k, spawn_if.oSpawnLane, oSpawnCount, e.lane, e.count);
                end
                @(negedge iClock);
                model_count++;
                checks++;
                if (spawn_if.oSpawnValid !== 1'b0 || oSpawnCount !== model_count) begin
                    errors++;
                    $display("FAIL b2b_pulse[%0d]: got valid %b count %0d expected 0 %0d",
                             k, spawn_if.oSpawnValid, oSpawnCount, model_count);
                end
            end
        end
        iEnable = 1'b0;
        repeat (3) @(negedge iClock);
        checks++;
        if (oRemaining !== '0) begin
            errors++;
            $display("FAIL b2b_stop: got remaining %0d expected 0", oRemaining);
        end
    endtask

    task automatic test_clamp();
        int c, seen;
        bit ok;
        spawn_exp_t e;
        logic [WIDTH-1:0] rnd[2];
        int               ival[2];
        rnd[0] = 32'd3;          ival[0] = MIN_I;
        rnd[1] = 32'hFFFF_FFFF;  ival[1] = MAX_I;
        spawn_if.iSpawnReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iRandom = rnd[k];
            iEnable = 1'b1;
            c = cyc;
            sb.push_back(spawn_exp_t'{c + ival[k] + 2, rnd[k][1:0], model_count});
            repeat (2) @(negedge iClock);
            checks++;
            if (oRemaining !== WIDTH'(ival[k])) begin
                errors++;
                $display("FAIL clamp_load[%0d]: got %0d expected %0d", k, oRemaining, ival[k]);
            end
            wait_valid(ival[k] + 10, seen, ok);
            iEnable = 1'b0;
            e = sb.pop_front();
            checks++;
            if (!ok || seen != e.cyc) begin
                errors++;
                $display("FAIL clamp_time[%0d]: got cycle %0d expected %0d", k, seen, e.cyc);
            end
            checks++;
            if (spawn_if.oSpawnLane !== e.lane || oSpawnCount !== e.count) begin
                errors++;
                $display("FAIL clamp_data[%0d]: got lane %0d count %0d expected %0d %0d",
                         k, spawn_if.oSpawnLane, oSpawnCount, e.lane, e.count);
            end
            @(negedge iClock);
            if (ok) model_count++;
        end
    endtask

    task automatic test_pause();
        int c, seen;
        bit ok;
        spawn_exp_t e;
        iRandom = 32'd100;
        spawn_if.iSpawnReady = 1'b1;
        iEnable = 1'b1;
        c = cyc;
        sb.push_back(spawn_exp_t'{c + 112, 2'd0, model_count});
        repeat (52) @(negedge iClock);
        checks++;
        if (oRemaining !== 32'd50) begin
            errors++;
            $display("FAIL pause_pre: got %0d expected 50", oRemaining);
        end
        iPause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge iClock);
            checks++;
            if (oRemaining !== 32'd50) begin
                errors++;
                $display("FAIL pause_hold[%0d]: got %0d expected 50", i, oRemaining);
            end
        end
        iPause = 1'b0;
        wait_valid(100, seen, ok);
        iEnable = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || seen != e.cyc) begin
            errors++;
            $display("FAIL pause_time: got cycle %0d expected %0d", seen, e.cyc);
        end
        @(negedge iClock);
        if (ok) model_count++;
        checks++;
        if (oSpawnCount !== model_count) begin
            errors++;
            $display("FAIL pause_count: got %0d expected %0d", oSpawnCount, model_count);
        end
    endtask

    task automatic test_hold();
        int c, seen;
        bit ok;
        spawn_exp_t e;
        iRandom = 32'd18;
        spawn_if.iSpawnReady = 1'b0;
        iEnable = 1'b1;
        c = cyc;
        sb.push_back(spawn_exp_t'{c + 20, 2'd2, model_count});
        wait_valid(40, seen, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || seen != e.cyc || spawn_if.oSpawnLane !== e.lane) begin
            errors++;
            $display("FAIL hold_fire: got cycle %0d lane %0d expected %0d %0d",
                     seen, spawn_if.oSpawnLane, e.cyc, e.lane);
        end
        for (int i = 0; i < 20; i++) begin
            iRandom = $urandom;
            iEnable = (i < 5);
            iPause  = 1'($urandom_range(0, 1));
            @(negedge iClock);
            checks++;
            if (spawn_if.oSpawnValid !== 1'b1 || spawn_if.oSpawnLane !== e.lane
                || oSpawnCount !== e.count) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid %b lane %0d count %0d expected 1 %0d %0d",
                         i, spawn_if.oSpawnValid, spawn_if.oSpawnLane, oSpawnCount, e.lane, e.count);
            end
        end
        iPause = 1'b0;
        spawn_if.iSpawnReady = 1'b1;
        @(negedge iClock);
        model_count++;
        checks++;
        if (spawn_if.oSpawnValid !== 1'b0 || oSpawnCount !== model_count) begin
            errors++;
            $display("FAIL hold_accept: got valid %b count %0d expected 0 %0d",
                     spawn_if.oSpawnValid, oSpawnCount, model_count);
        end
        repeat (3) @(negedge iClock);
        checks++;
        if (spawn_if.oSpawnValid !== 1'b0 || oRemaining !== '0) begin
            errors++;
            $display("FAIL hold_idle: got valid %b remaining %0d expected 0 0",
                     spawn_if.oSpawnValid, oRemaining);
        end
    endtask

    task automatic test_lane_abort();
        int c, seen;
        bit ok, saw_valid;
        spawn_exp_t e;
        iRandom = 32'd20;
        spawn_if.iSpawnReady = 1'b1;
        iEnable = 1'b1;
        c = cyc;
        sb.push_back(spawn_exp_t'{c + 22, 2'd2, model_count});
        repeat (2) @(negedge iClock);
        // Low bits 2'b10 only after the interval has been sampled.
        iRandom = 32'hABCD_0012;
        wait_valid(40, seen, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || seen != e.cyc || spawn_if.oSpawnLane !== e.lane) begin
            errors++;
            $display("FAIL lane_fire: got cycle %0d lane %0d expected %0d %0d",
                     seen, spawn_if.oSpawnLane, e.cyc, e.lane);
        end
        @(negedge iClock);
        if (ok) model_count++;
        // Accepted with enable high: reload, clamped to MAX_I, now counting down.
        repeat (30) @(negedge iClock);
        checks++;
        if (oRemaining !== WIDTH'(MAX_I - 29)) begin
            errors++;
            $display("FAIL reload_count: got %0d expected %0d", oRemaining, MAX_I - 29);
        end
        iEnable = 1'b0;
        @(negedge iClock);
        checks++;
        if (oRemaining !== '0) begin
            errors++;
            $display("FAIL abort_clear: got %0d expected 0", oRemaining);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge iClock);
            if (spawn_if.oSpawnValid !== 1'b0 || oRemaining !== '0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || oSpawnCount !== model_count) begin
            errors++;
            $display("FAIL abort_nospawn: got activity %b count %0d expected 0 %0d",
                     saw_valid, oSpawnCount, model_count);
        end
    endtask

    task automatic test_reset_mid_fire();
        int c, seen;
        bit ok;
        spawn_exp_t e;
        iRandom = 32'd17;
        spawn_if.iSpawnReady = 1'b0;
        iEnable = 1'b1;
        c = cyc;
        sb.push_back(spawn_exp_t'{c + 19, 2'd1, model_count});
        wait_valid(40, seen, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || seen != e.cyc || spawn_if.oSpawnLane !== e.lane) begin
            errors++;
            $display("FAIL rst_fire: got cycle %0d lane %0d expected %0d %0d",
                     seen, spawn_if.oSpawnLane, e.cyc, e.lane);
        end
        #2 iResetN = 1'b0;
        #1;
        checks++;
        if (spawn_if.oSpawnValid !== 1'b0 || spawn_if.oSpawnLane !== 2'd0
            || oSpawnCount !== 16'd0 || oRemaining !== '0) begin
            errors++;
            $display("FAIL rst_async: got valid %b lane %0d count %0d remaining %0d expected all 0",
                     spawn_if.oSpawnValid, spawn_if.oSpawnLane, oSpawnCount, oRemaining);
        end
        iEnable = 1'b0;
        @(negedge iClock);
        iResetN = 1'b1;
        model_count = '0;
        @(negedge iClock);
        checks++;
        if (spawn_if.oSpawnValid !== 1'b0 || oSpawnCount !== 16'd0) begin
            errors++;
            $display("FAIL rst_release: got valid %b count %0d expected 0 0",
                     spawn_if.oSpawnValid, oSpawnCount);
        end
    endtask

    task automatic test_count_wrap();
        int c, seen;
        bit ok;
        spawn_exp_t e;
        // Preload the accept counter; walking it through 65535 spawns is too long.
        force dut.spawn_count = 16'hFFFF;
        @(negedge iClock);
        release dut.spawn_count;
        model_count = 16'hFFFF;
        iRandom = 32'd16;
        spawn_if.iSpawnReady = 1'b1;
        iEnable = 1'b1;
        c = cyc;
        sb.push_back(spawn_exp_t'{c + 18, 2'd0, model_count});
        wait_valid(40, seen, ok);
        iEnable = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || seen != e.cyc || oSpawnCount !== e.count) begin
            errors++;
            $display("FAIL wrap_fire: got cycle %0d count %0d expected %0d %0d",
                     seen, oSpawnCount, e.cyc, e.count);
        end
        @(negedge iClock);
        model_count++;
        checks++;
        if (oSpawnCount !== model_count) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected %0d", oSpawnCount, model_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_clamp();
        test_pause();
        test_hold();
        test_lane_abort();
        test_reset_mid_fire();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
